combo_lock_datapath: RTL and testbench

Datapath for the combination lock, sitting between the switch/button conditioning logic, the lock control FSM and the 4-digit seven-segment display. It consumes the FSM's `ShiftA`, `ShiftB`, `ResetA` and `Selector` outputs and performs four jobs:
- captures the entered digits;
- stores and updates the secret combination;
- returns the `Pass` and `Reverse` comparison flags;
- drives the multiplexed display.

---
 rtl/combo_lock_datapath_if.sv | 25 ++
 rtl/combo_lock_datapath.sv | 159 +++++++++++++++
 tb/tb_combo_lock_datapath.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/combo_lock_datapath_if.sv
// Bundle of the lock datapath's control inputs from the FSM/conditioning logic
// and its comparison/display outputs.
interface combo_lock_datapath_if;
   logic [3:0] Digit;
   logic       Validate;
   logic       Change;
   logic       ShiftA;
   logic       ShiftB;
   logic       ResetA;
   logic [2:0] Selector;
   logic       Pass;
   logic       Reverse;
   logic [3:0] An;
   logic [6:0] Seg;

   modport master (
      output Digit, Validate, Change, ShiftA, ShiftB, ResetA, Selector,
      input  Pass, Reverse, An, Seg
   );

   modport slave (
      input  Digit, Validate, Change, ShiftA, ShiftB, ResetA, Selector,
      output Pass, Reverse, An, Seg
   );
endinterface

// File: rtl/combo_lock_datapath.sv
// Combination lock datapath: entered-code register A, staging register S and
// stored code B, Pass/Reverse comparison, and multiplexed 7-segment display.
module combo_lock_datapath #(
   parameter logic [15:0] DEFAULT_CODE = 16'h1234,
   parameter int unsigned REFRESH_BITS = 18
) (
   input logic                  Clock,
   input logic                  Reset,
   combo_lock_datapath_if.slave Lock
);

   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_O     = 7'b1000000;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_K     = 7'b0001010;
   localparam logic [6:0] SEG_P     = 7'b0001100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_S     = 7'b0010010;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_I     = 7'b1111001;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   logic [15:0]             a_q, a_d;
   logic [15:0]             s_q, s_d;
   logic [15:0]             b_q, b_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
   logic [3:0]              an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic [15:0]             rev_b;
   logic [15:0]             src;
   logic [1:0]              k, q, idx;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Entered-code shifting plus staged new-code entry committing on the fourth digit
   always_comb begin
      a_d   = a_q;
      s_d   = s_q;
      b_d   = b_q;
      cnt_d = cnt_q;
      if (Lock.ResetA)
         a_d = '0;
      else if (Lock.ShiftA && Lock.Change)
         a_d = '0;
      else if (Lock.ShiftA && Lock.Validate)
         a_d = {a_q[11:0], Lock.Digit};
      if (!Lock.ShiftB) begin
         cnt_d = '0;
      end else if (Lock.Change) begin
         cnt_d = '0;
         s_d   = '0;
      end else if (Lock.Validate) begin
         if (cnt_q == 2'd3) begin
            b_d   = {s_q[11:0], Lock.Digit};
            s_d   = '0;
            cnt_d = '0;
         end else begin
            s_d   = {s_q[11:0], Lock.Digit};
            cnt_d = cnt_q + 2'd1;
         end
      end
   end

   // Code registers; B falls back to the default code on every reset
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         a_q   <= '0;
         s_q   <= '0;
         b_q   <= DEFAULT_CODE;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         s_q   <= s_d;
         b_q   <= b_d;
         cnt_q <= cnt_d;
      end
   end

   assign rev_b        = {b_q[3:0], b_q[7:4], b_q[11:8], b_q[15:12]};
   assign Lock.Pass    = (a_q == b_q);
   assign Lock.Reverse = (a_q == rev_b) && (b_q != rev_b);

   // Glyph for the position k currently addressed by the refresh counter.
   // In entry modes q is the live-digit position; positions left of it show
   // earlier digits, most recent (nibble 0) adjacent to q.
   always_comb begin
      k         = refresh_q[REFRESH_BITS-1 -: 2];
      q         = 2'(3'd4 - Lock.Selector);
      idx       = k - q - 2'd1;
      src       = Lock.ShiftB ? s_q : a_q;
      refresh_d = refresh_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      an_d      = ~(4'b0001 << k);
      seg_d     = SEG_DASH;
      case (Lock.Selector)
         3'b000: case (k)
            2'd3: seg_d = SEG_L;
            2'd2: seg_d = SEG_O;
            2'd1: seg_d = SEG_C;
            default: seg_d = SEG_K;
         endcase
         3'b101: seg_d = SEG_BLANK;
         3'b110: case (k)
            2'd3: seg_d = SEG_P;
            2'd2: seg_d = SEG_A;
            default: seg_d = SEG_S;
         endcase
         3'b111: case (k)
            2'd3: seg_d = SEG_F;
            2'd2: seg_d = SEG_A;
            2'd1: seg_d = SEG_I;
            default: seg_d = SEG_L;
         endcase
         default: begin
            if (k == q)
               seg_d = hex7(Lock.Digit);
            else if (k > q)
               seg_d = hex7(src[{idx, 2'b00} +: 4]);
         end
      endcase
   end

   // Refresh counter and registered display drive
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         refresh_q <= '0;
         an_q      <= '1;
         seg_q     <= '1;
      end else begin
         refresh_q <= refresh_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign Lock.An  = an_q;
   assign Lock.Seg = seg_q;

endmodule

// File: tb/tb_combo_lock_datapath.sv
// Scoreboard bench for combo_lock_datapath: stimulus updates a digit-level
// reference model and queues expected outputs; a negedge monitor compares.
module tb_combo_lock_datapath;
   localparam int unsigned RB = 4;

   logic Clock = 1'b0;
   logic Reset = 1'b1;

   combo_lock_datapath_if ifc ();

   combo_lock_datapath #(
      .DEFAULT_CODE(16'h1234),
      .REFRESH_BITS(RB)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .Lock (ifc)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic       pass;
      logic       rev;
      logic [3:0] an;
      logic [6:0] seg;
   } exp_t;

   exp_t sbq[$];
   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int unsigned m_a, m_b, m_s, m_cnt, ticks;

   function automatic logic [6:0] hexg(input int unsigned v);
      case (v % 16)
         0: return 7'b1000000;  1: return 7'b1111001;
         2: return 7'b0100100;  3: return 7'b0110000;
         4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;
         8: return 7'b0000000;  9: return 7'b0010000;
         10: return 7'b0001000; 11: return 7'b0000011;
         12: return 7'b1000110; 13: return 7'b0100001;
         14: return 7'b0000110; default: return 7'b0001110;
      endcase
   endfunction

   function automatic int unsigned revd(input int unsigned x);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 4; i++) r = r * 16 + ((x >> (4 * i)) % 16);
      return r;
   endfunction

   // glyph at anode position pos (0 = rightmost), reading the panel left to right
   function automatic logic [6:0] glyph_at(input int unsigned pos, input logic [2:0] sel,
                                           input int unsigned dig, input int unsigned src);
      int unsigned col, n;
      col = 3 - pos;
      case (sel)
         3'd0: case (col) 0: return 7'b1000111; 1: return 7'b1000000;
                          2: return 7'b1000110; default: return 7'b0001010; endcase
         3'd5: return 7'h7F;
         3'd6: case (col) 0: return 7'b0001100; 1: return 7'b0001000;
                          default: return 7'b0010010; endcase
         3'd7: case (col) 0: return 7'b0001110; 1: return 7'b0001000;
                          2: return 7'b1111001; default: return 7'b1000111; endcase
         default: begin
            n = int'(sel) - 1;  // digits already entered, oldest leftmost
            if (col < n) return hexg(src >> (4 * (n - 1 - col)));
            else if (col == n) return hexg(dig);
            else return 7'b0111111;
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("Pass",    16'(ifc.Pass),    16'(e.pass));
         chk("Reverse", 16'(ifc.Reverse), 16'(e.rev));
         chk("An",      16'(ifc.An),      16'(e.an));
         chk("Seg",     16'(ifc.Seg),     16'(e.seg));
      end
   end

   function automatic exp_t flags(input exp_t e);
      exp_t r;
      r      = e;
      r.pass = (m_a == m_b);
      r.rev  = (m_a == revd(m_b)) && (m_b != revd(m_b));
      return r;
   endfunction

   task automatic step(input logic v, input logic c, input int unsigned d,
                       input logic sa, input logic sb, input logic ra, input logic [2:0] sel);
      exp_t e;
      int unsigned pos;
      logic [3:0] one;
      one = 4'b0001;
      ifc.Validate = v;
      ifc.Change   = c;
      ifc.Digit    = 4'(d);
      ifc.ShiftA   = sa;
      ifc.ShiftB   = sb;
      ifc.ResetA   = ra;
      ifc.Selector = sel;
      pos   = (ticks >> (RB - 2)) % 4;
      e     = '0;
      e.an  = ~(one << pos);
      e.seg = glyph_at(pos, sel, d, sb ? m_s : m_a);
      @(posedge Clock);
      if (ra) m_a = 0;
      else if (sa && c) m_a = 0;
      else if (sa && v) m_a = (m_a * 16 + d) % 65536;
      if (!sb) m_cnt = 0;
      else if (c) begin m_cnt = 0; m_s = 0; end
      else if (v) begin
         if (m_cnt == 3) begin
            m_b = (m_s * 16 + d) % 65536; m_s = 0; m_cnt = 0;
         end else begin
            m_s = (m_s * 16 + d) % 65536; m_cnt++;
         end
      end
      ticks = (ticks + 1) % (1 << RB);
      sbq.push_back(flags(e));
      #1;
   endtask

   task automatic do_reset();
      exp_t e;
      @(negedge Clock);
      #1;
      ifc.Validate = 0; ifc.Change = 0; ifc.ShiftA = 0; ifc.ShiftB = 0;
      ifc.ResetA = 0; ifc.Selector = 0; ifc.Digit = 0;
      Reset = 1'b1;
      m_a = 0; m_b = 16'h1234; m_s = 0; m_cnt = 0; ticks = 0;
      e = '0; e.an = 4'hF; e.seg = 7'h7F;
      sbq.push_back(flags(e));
      @(negedge Clock);
      @(posedge Clock);
      #1 Reset = 1'b0;
   endtask

   task automatic enter(input int unsigned code, input logic sa, input logic sb);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, (code >> (4 * (3 - i))) % 16, sa, sb, 0, 3'(i + 1));
         step(0, 0, $urandom_range(0, 15), sa, sb, 0, 3'(i + 2));
      end
   endtask

   initial begin
      logic sa, sb;
      #1;
      do_reset();
      repeat (20) step(0, 0, 0, 0, 0, 0, 3'd0);            // LOCk scan
      enter(16'h1234, 1, 0); repeat (3) step(0, 0, 0, 1, 0, 0, 3'd6);
      step(0, 0, 0, 0, 0, 1, 3'd0);
      enter(16'h4321, 1, 0); repeat (3) step(0, 0, 0, 1, 0, 0, 3'd7);
      step(0, 0, 0, 0, 0, 1, 3'd0);
      enter(16'h1221, 0, 1);                                // palindrome code
      enter(16'h1221, 1, 0); repeat (2) step(0, 0, 0, 1, 0, 0, 3'd6);
      // code change while A holds the old code: Pass holds until 4th validate
      step(1, 0, 9, 0, 1, 0, 3'd1); step(1, 0, 8, 0, 1, 0, 3'd2);
      step(0, 1, 0, 0, 1, 0, 3'd3);
      enter(16'h5678, 0, 1); repeat (2) step(0, 0, 0, 0, 0, 0, 3'd5);
      step(0, 0, 0, 0, 0, 1, 3'd0);
      enter(16'h5678, 1, 0); repeat (2) step(0, 0, 0, 1, 0, 0, 3'd6);
      // priority: Change beats Validate, ResetA beats everything
      step(0, 0, 0, 0, 0, 1, 3'd0);
      step(1, 0, 1, 1, 0, 0, 3'd1); step(1, 0, 2, 1, 0, 0, 3'd2);
      step(1, 1, 7, 1, 0, 0, 3'd3);
      repeat (16) step(0, 0, 0, 1, 0, 0, 3'd4);
      step(1, 0, 5, 1, 0, 0, 3'd1); step(1, 0, 6, 1, 0, 1, 3'd2);
      repeat (16) step(0, 0, 0, 1, 0, 0, 3'd4);
      // entry display with A=0x0003, live digit 7
      step(1, 0, 3, 1, 0, 0, 3'd1);
      repeat (16) step(0, 0, 7, 1, 0, 0, 3'd2);
      repeat (4) step(1, 0, 9, 0, 0, 0, 3'd2);             // validate with no shift
      // reset mid set-sequence restores the default code
      step(1, 0, 9, 0, 1, 0, 3'd1); step(1, 0, 8, 0, 1, 0, 3'd2);
      do_reset();
      enter(16'h1234, 1, 0); repeat (3) step(0, 0, 0, 1, 0, 0, 3'd6);
      // randomized traffic
      sa = 0; sb = 0;
      for (int n = 0; n < 400; n++) begin
         if (n % 16 == 0) begin
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
         end
         step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 15),
              sa, sb, $urandom_range(0, 29) == 0, 3'($urandom_range(0, 7)));
      end
      repeat (3) @(negedge Clock);
      vectors++;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
